matrix_row_ram: RTL and testbench

Parametrised row-wide on-chip RAM for the matrix datapath: each word is one matrix row of N lanes × DATA_LEN bits, DEPTH rows deep, intended to map to M10K. Compared with the earlier fixed row memory, it adds per-lane write masking, write-first read-during-write forwarding, and a read-valid flag. It also has a hardware init/clear sequencer that fills contents after reset, because an asynchronous reset cannot initialise RAM. It sits between the host loader and the matrix compute engine as operand/result storage.

---
 rtl/matrix_row_ram.sv | 136 +++++++++++++
 tb/tb_matrix_row_ram.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/matrix_row_ram.sv
// rtl/matrix_row_ram.sv - row-wide matrix RAM with lane masks, write-first forwarding and init/clear sequencer
module matrix_row_ram #(
  parameter int DATA_LEN     = 32,
  parameter int N            = 8,
  parameter int DEPTH        = 16,
  parameter int ADDRESS_SIZE = 4,
  parameter int INIT_RAMP    = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [DATA_LEN*N-1:0]      i_write_data,
  input  logic [ADDRESS_SIZE-1:0]    i_write_address,
  input  logic                       i_wr_en,
  input  logic [N-1:0]               i_wr_lane_mask,
  input  logic [ADDRESS_SIZE-1:0]    i_read_address,
  input  logic                       i_rd_en,
  input  logic                       i_clear,
  output logic [DATA_LEN*N-1:0]      o_read_data,
  output logic                       o_read_valid,
  output logic                       o_busy
);

  localparam int ROW_W = DATA_LEN * N;
  localparam logic [ADDRESS_SIZE-1:0] LAST_ROW = ADDRESS_SIZE'(DEPTH - 1);

  typedef enum logic [1:0] {INIT, IDLE, CLEAR} state_t;

  state_t                  state;
  logic [ADDRESS_SIZE-1:0] ptr;

  logic [ROW_W-1:0] mem [0:DEPTH-1];

  logic                    wr_in_range;
  logic                    rd_in_range;
  logic                    host_wr;
  logic                    host_rd;
  logic                    mem_we;
  logic [ADDRESS_SIZE-1:0] mem_addr;
  logic [ROW_W-1:0]        mem_data;
  logic [N-1:0]            mem_mask;
  logic [ROW_W-1:0]        fill_row;
  logic [ROW_W-1:0]        rd_row;

  always_comb begin
    wr_in_range = (32'(i_write_address) < 32'(DEPTH));
    rd_in_range = (32'(i_read_address) < 32'(DEPTH));
    host_wr     = (state == IDLE) && i_wr_en && wr_in_range;
    host_rd     = (state == IDLE) && i_rd_en;
  end

  // Fill pattern is only the ramp during INIT; CLEAR always writes zero.
  always_comb begin
    fill_row = '0;
    for (int k = 0; k < N; k++) begin
      if (INIT_RAMP != 0 && state == INIT)
        fill_row[k*DATA_LEN +: DATA_LEN] = DATA_LEN'(int'(ptr) * N + k);
    end
  end

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    mem_mask = '0;
    if (state != IDLE) begin
      mem_we   = 1'b1;
      mem_addr = ptr;
      mem_data = fill_row;
      mem_mask = '1;
    end else if (host_wr) begin
      mem_we   = 1'b1;
      mem_addr = i_write_address;
      mem_data = i_write_data;
      mem_mask = i_wr_lane_mask;
    end
  end

  // Write-first: lanes being written this cycle to the read row take the new data.
  always_comb begin
    rd_row = '0;
    if (rd_in_range) begin
      rd_row = mem[i_read_address];
      for (int k = 0; k < N; k++) begin
        if (host_wr && i_write_address == i_read_address && i_wr_lane_mask[k])
          rd_row[k*DATA_LEN +: DATA_LEN] = i_write_data[k*DATA_LEN +: DATA_LEN];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      for (int k = 0; k < N; k++) begin
        if (mem_mask[k])
          mem[mem_addr][k*DATA_LEN +: DATA_LEN] <= mem_data[k*DATA_LEN +: DATA_LEN];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= INIT;
      ptr          <= '0;
      o_busy       <= 1'b1;
      o_read_data  <= '0;
      o_read_valid <= 1'b0;
    end else begin
      o_read_valid <= host_rd;
      if (host_rd)
        o_read_data <= rd_row;
      case (state)
        INIT, CLEAR: begin
          if (ptr == LAST_ROW) begin
            state  <= IDLE;
            ptr    <= '0;
            o_busy <= 1'b0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        IDLE: begin
          if (i_clear) begin
            state  <= CLEAR;
            ptr    <= '0;
            o_busy <= 1'b1;
          end
        end
        default: begin
          state  <= INIT;
          ptr    <= '0;
          o_busy <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_row_ram.sv
// tb/tb_matrix_row_ram.sv - directed self-checking bench for matrix_row_ram
module tb_matrix_row_ram;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [255:0] wdata;
  logic [3:0]   waddr;
  logic         wr_en;
  logic [7:0]   mask;
  logic [3:0]   raddr;
  logic         rd_en;
  logic         clear;
  logic [255:0] rdata;
  logic         rvalid;
  logic         busy;

  logic [255:0] wdata_b;
  logic [3:0]   waddr_b;
  logic         wr_en_b;
  logic [7:0]   mask_b;
  logic [3:0]   raddr_b;
  logic         rd_en_b;
  logic [255:0] rdata_b;
  logic         rvalid_b;
  logic         busy_b;

  int checks = 0;
  int failures = 0;
  int cnt;

  always #5 clk = ~clk;

  matrix_row_ram #(.DATA_LEN(32), .N(8), .DEPTH(16), .ADDRESS_SIZE(4), .INIT_RAMP(1)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_write_data(wdata), .i_write_address(waddr),
    .i_wr_en(wr_en), .i_wr_lane_mask(mask), .i_read_address(raddr), .i_rd_en(rd_en),
    .i_clear(clear), .o_read_data(rdata), .o_read_valid(rvalid), .o_busy(busy)
  );

  matrix_row_ram #(.DATA_LEN(32), .N(8), .DEPTH(12), .ADDRESS_SIZE(4), .INIT_RAMP(1)) u_dut12 (
    .i_clk(clk), .i_rst_n(rst_n), .i_write_data(wdata_b), .i_write_address(waddr_b),
    .i_wr_en(wr_en_b), .i_wr_lane_mask(mask_b), .i_read_address(raddr_b), .i_rd_en(rd_en_b),
    .i_clear(1'b0), .o_read_data(rdata_b), .o_read_valid(rvalid_b), .o_busy(busy_b)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lane(input logic [255:0] row, input int k);
    return row[k*32 +: 32];
  endfunction

  function automatic logic [255:0] ramp(input int r);
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = 32'(r * 8 + k);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_row(input logic [3:0] a);
    raddr = a;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  task automatic read_row_b(input logic [3:0] a);
    raddr_b = a;
    rd_en_b = 1'b1;
    step();
    rd_en_b = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    wdata = '0; waddr = '0; wr_en = 1'b0; mask = '0; raddr = '0; rd_en = 1'b0; clear = 1'b0;
    wdata_b = '0; waddr_b = '0; wr_en_b = 1'b0; mask_b = '0; raddr_b = '0; rd_en_b = 1'b0;
    repeat (3) step();
    check("reset_busy", 256'(busy), 256'(1));
    check("reset_valid", 256'(rvalid), 256'(0));
    check("reset_data", rdata, '0);

    rst_n = 1'b1;
    wait_idle(cnt);
    check("init_cycles", 256'(cnt), 256'(16));
    check("init12_done", 256'(busy_b), 256'(0));

    read_row(4'd3);
    check("row3_valid", 256'(rvalid), 256'(1));
    check("row3_data", rdata, ramp(3));
    step();
    check("valid_pulse", 256'(rvalid), 256'(0));
    check("data_hold", rdata, ramp(3));

    read_row(4'd15);
    check("row15_l0", 256'(lane(rdata, 0)), 256'(120));
    check("row15_l7", 256'(lane(rdata, 7)), 256'(127));

    for (int k = 0; k < 8; k++) wdata[k*32 +: 32] = 32'hDEAD_0000 + 32'(k);
    waddr = 4'd2; mask = 8'b0000_0101; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
    read_row(4'd2);
    check("mask_l0", 256'(lane(rdata, 0)), 256'(32'hDEAD_0000));
    check("mask_l2", 256'(lane(rdata, 2)), 256'(32'hDEAD_0002));
    check("mask_l1", 256'(lane(rdata, 1)), 256'(17));
    check("mask_l7", 256'(lane(rdata, 7)), 256'(23));

    wdata = {8{32'hFFFF_FFFF}};
    waddr = 4'd5; raddr = 4'd5; mask = 8'h0F; wr_en = 1'b1; rd_en = 1'b1;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    check("rdw_valid", 256'(rvalid), 256'(1));
    check("rdw_data", rdata, {32'd47, 32'd46, 32'd45, 32'd44, {4{32'hFFFF_FFFF}}});

    wdata = '0; waddr = 4'd0; mask = 8'hFF; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
    read_row(4'd0);
    check("zero_mask_ref", rdata, '0);

    clear = 1'b1;
    step();
    clear = 1'b0;
    raddr = 4'd3; rd_en = 1'b1;
    cnt = 0;
    while (busy && cnt < 100) begin
      step();
      cnt++;
      if (rvalid) check("busy_rd_ignored", 256'(rvalid), 256'(0));
    end
    rd_en = 1'b0;
    check("clear_cycles", 256'(cnt), 256'(16));
    read_row(4'd0);
    check("clear_row0", rdata, '0);
    read_row(4'd15);
    check("clear_row15_valid", 256'(rvalid), 256'(1));
    check("clear_row15", rdata, '0);

    wdata = {8{32'hA5A5_5A5A}}; waddr = 4'd1; mask = 8'hFF; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
    raddr = 4'd1; rd_en = 1'b1; clear = 1'b1;
    step();
    rd_en = 1'b0; clear = 1'b0;
    check("clear_rd_valid", 256'(rvalid), 256'(1));
    check("clear_rd_data", rdata, {8{32'hA5A5_5A5A}});
    check("clear_started", 256'(busy), 256'(1));
    repeat (6) step();
    rst_n = 1'b0;
    #1;
    check("abort_data", rdata, '0);
    check("abort_valid", 256'(rvalid), 256'(0));
    check("abort_busy", 256'(busy), 256'(1));
    step();
    step();
    rst_n = 1'b1;
    wait_idle(cnt);
    check("reinit_cycles", 256'(cnt), 256'(16));
    read_row(4'd10);
    check("reinit_row10_l0", 256'(lane(rdata, 0)), 256'(80));
    read_row(4'd1);
    check("reinit_row1", rdata, ramp(1));

    wdata_b = {8{32'h1234_5678}}; waddr_b = 4'd13; mask_b = 8'hFF; wr_en_b = 1'b1;
    step();
    wr_en_b = 1'b0;
    read_row_b(4'd11);
    read_row_b(4'd13);
    check("oor_valid", 256'(rvalid_b), 256'(1));
    check("oor_data", rdata_b, '0);
    read_row_b(4'd11);
    check("d12_row11", rdata_b, ramp(11));
    read_row_b(4'd1);
    check("d12_row1", rdata_b, ramp(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
